// File: rtl/fetch_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fetch_aligner
// Brief   : RV32IC fetch aligner. Buffers fetched words as halfwords and
//           presents one 16- or 32-bit instruction per handshake.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i
);

    localparam int          C_DEPTH     = 4;
    localparam logic [31:0] C_BOOT_PC   = {BOOT_ADDR[31:1], 1'b0};
    localparam logic [31:0] C_BOOT_WORD = {BOOT_ADDR[31:2], 2'b00};

    logic [15:0] hw_buf_q [C_DEPTH];
    logic [15:0] hw_buf_d [C_DEPTH];
    logic [2:0]  hw_cnt_q, hw_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        outstanding_q, outstanding_d;
    logic        kill_q, kill_d;
    logic        drop_low_q, drop_low_d;

    logic        w_head_compressed;
    logic        w_valid;
    logic        w_pop;
    logic [2:0]  w_pop_cnt;
    logic [2:0]  w_cnt_after_pop;
    logic [1:0]  w_wr_idx;
    logic        w_grant;
    logic        w_resp;
    logic        unused_target_bit0;

    assign w_head_compressed = (hw_buf_q[0][1:0] != 2'b11);
    assign w_valid           = w_head_compressed ? (hw_cnt_q != 3'd0) : (hw_cnt_q >= 3'd2);
    assign w_pop             = w_valid && instr_ready_i && !branch_i;
    assign w_pop_cnt         = !w_pop ? 3'd0 : (w_head_compressed ? 3'd1 : 3'd2);
    assign w_cnt_after_pop   = hw_cnt_q - w_pop_cnt;
    assign w_wr_idx          = w_cnt_after_pop[1:0];

    // A new word is only requested once it is guaranteed to fit behind the
    // halfwords still held after this cycle's pop.
    assign mem_req_o = !rst && !outstanding_q && !branch_i && (w_cnt_after_pop <= 3'd2);
    assign w_grant   = mem_req_o && mem_gnt_i;
    assign w_resp    = mem_rvalid_i && outstanding_q;

    assign mem_addr_o         = fetch_addr_q;
    assign instr_valid_o      = w_valid;
    assign instr_pc_o         = pc_q;
    assign instr_compressed_o = w_valid && w_head_compressed;
    assign instr_o            = !w_valid          ? 32'd0 :
                                w_head_compressed ? {16'd0, hw_buf_q[0]} :
                                                    {hw_buf_q[1], hw_buf_q[0]};

    assign unused_target_bit0 = branch_target_i[0];

    always_comb begin
        for (int i = 0; i < C_DEPTH; i++) begin
            hw_buf_d[i] = hw_buf_q[i];
        end
        hw_cnt_d      = w_cnt_after_pop;
        pc_d          = pc_q + {28'd0, w_pop_cnt, 1'b0};
        fetch_addr_d  = fetch_addr_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        drop_low_d    = drop_low_q;

        case (w_pop_cnt)
            3'd1: begin
                hw_buf_d[0] = hw_buf_q[1];
                hw_buf_d[1] = hw_buf_q[2];
                hw_buf_d[2] = hw_buf_q[3];
            end
            3'd2: begin
                hw_buf_d[0] = hw_buf_q[2];
                hw_buf_d[1] = hw_buf_q[3];
            end
            default: ;
        endcase

        if (w_grant) begin
            outstanding_d = 1'b1;
            fetch_addr_d  = fetch_addr_q + 32'd4;
        end

        // Responses land behind whatever survived this cycle's pop.
        if (w_resp) begin
            outstanding_d = 1'b0;
            if (kill_q) begin
                kill_d = 1'b0;
            end else if (drop_low_q) begin
                hw_buf_d[w_wr_idx] = mem_rdata_i[31:16];
                hw_cnt_d           = w_cnt_after_pop + 3'd1;
                drop_low_d         = 1'b0;
            end else begin
                hw_buf_d[w_wr_idx]         = mem_rdata_i[15:0];
                hw_buf_d[w_wr_idx + 2'd1]  = mem_rdata_i[31:16];
                hw_cnt_d                   = w_cnt_after_pop + 3'd2;
            end
        end

        // A redirect flushes everything; an in-flight word is marked for discard.
        if (branch_i) begin
            hw_cnt_d      = 3'd0;
            pc_d          = {branch_target_i[31:1], 1'b0};
            fetch_addr_d  = {branch_target_i[31:2], 2'b00};
            drop_low_d    = branch_target_i[1];
            kill_d        = outstanding_q && !mem_rvalid_i;
            outstanding_d = outstanding_q && !mem_rvalid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                hw_buf_q[i] <= 16'd0;
            end
            hw_cnt_q      <= 3'd0;
            pc_q          <= C_BOOT_PC;
            fetch_addr_q  <= C_BOOT_WORD;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
            drop_low_q    <= BOOT_ADDR[1];
        end else begin
            for (int i = 0; i < C_DEPTH; i++) begin
                hw_buf_q[i] <= hw_buf_d[i];
            end
            hw_cnt_q      <= hw_cnt_d;
            pc_q          <= pc_d;
            fetch_addr_q  <= fetch_addr_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            drop_low_q    <= drop_low_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fetch_aligner
// Brief   : Randomized bench for fetch_aligner against an instruction-stream
//           model derived from a memory image and the expected PC.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_compressed_o;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;

    fetch_aligner #(.BOOT_ADDR(32'h0000_0000)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_req_o          (mem_req_o),
        .mem_addr_o         (mem_addr_o),
        .mem_gnt_i          (mem_gnt_i),
        .mem_rvalid_i       (mem_rvalid_i),
        .mem_rdata_i        (mem_rdata_i),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .instr_o            (instr_o),
        .instr_pc_o         (instr_pc_o),
        .instr_compressed_o (instr_compressed_o),
        .branch_i           (branch_i),
        .branch_target_i    (branch_target_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Memory image (1 KiB, wraps) and in-flight responses.
    logic [31:0] mem [256];
    logic [31:0] q_addr [$];
    int          q_due [$];
    int          last_due = 0;
    int          stale_n = 0;

    int          cyc = 0;
    logic [31:0] exp_pc = 32'd0;
    bit          exp_redir = 1'b1;
    logic [31:0] exp_fetch = 32'd0;

    int          gnt_pct, ready_pct, br_pct, lat_min, lat_max;
    bit          force_br = 1'b0;
    logic [31:0] force_tgt = 32'd0;

    int          n_hs = 0;
    logic [31:0] log_instr [$];
    logic [31:0] log_pc [$];
    logic        log_c [$];
    int          first_req_cyc, first_valid_cyc;
    logic [31:0] first_pc, first_instr;

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // {compressed, instruction} of the instruction starting at pc.
    function automatic logic [32:0] model_instr(input logic [31:0] pc);
        logic [15:0] lo;
        lo = hw_at(pc);
        if (lo[1:0] != 2'b11) return {1'b1, 16'd0, lo};
        return {1'b0, hw_at(pc + 32'd2), lo};
    endfunction

    task automatic step();
        int          d;
        bit          pend_live;
        logic [32:0] m;
        @(posedge clk);
        #1;
        cyc++;
        pend_live = (q_due.size() > stale_n);
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem[q_addr[0][9:2]];
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
            if (stale_n > 0) stale_n--;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
        instr_ready_i   = ($urandom_range(0, 99) < ready_pct);
        branch_i        = force_br || ($urandom_range(0, 99) < br_pct);
        branch_target_i = force_br ? force_tgt : {22'd0, 10'($urandom_range(0, 1023))};
        mem_gnt_i       = (q_due.size() == 0) && ($urandom_range(0, 99) < gnt_pct);
        #1;
        check_eq("hw_cnt_bound", {31'd0, dut.hw_cnt_q <= 3'd4}, 32'd1);
        if (branch_i) check_eq("no_req_on_redirect", {31'd0, mem_req_o}, 32'd0);
        if (mem_req_o) begin
            check_eq("req_while_outstanding", {31'd0, pend_live}, 32'd0);
            check_eq("addr_align", {30'd0, mem_addr_o[1:0]}, 32'd0);
            if (exp_redir) begin
                check_eq("redirect_fetch_addr", mem_addr_o, exp_fetch);
                exp_redir = 1'b0;
            end
        end
        m = model_instr(exp_pc);
        if (instr_valid_o) begin
            check_eq("instr", instr_o, m[31:0]);
            check_eq("instr_pc", instr_pc_o, exp_pc);
            check_eq("instr_compressed", {31'd0, instr_compressed_o}, {31'd0, m[32]});
            if (first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                first_pc        = instr_pc_o;
                first_instr     = instr_o;
            end
        end
        if (mem_req_o && mem_gnt_i) begin
            d = cyc + 1 + $urandom_range(lat_min, lat_max);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            q_due.push_back(d);
            q_addr.push_back(mem_addr_o);
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (branch_i) begin
            exp_pc    = {branch_target_i[31:1], 1'b0};
            exp_fetch = {branch_target_i[31:2], 2'b00};
            exp_redir = 1'b1;
        end else if (instr_valid_o && instr_ready_i) begin
            n_hs++;
            log_instr.push_back(instr_o);
            log_pc.push_back(instr_pc_o);
            log_c.push_back(instr_compressed_o);
            exp_pc = exp_pc + (m[32] ? 32'd2 : 32'd4);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   {31'd0, mem_req_o}, 32'd0);
        check_eq({tag, "_addr"},  mem_addr_o, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
        check_eq({tag, "_instr"}, instr_o, 32'd0);
        check_eq({tag, "_pc"},    instr_pc_o, 32'd0);
        check_eq({tag, "_cmp"},   {31'd0, instr_compressed_o}, 32'd0);
        check_eq({tag, "_cnt"},   {29'd0, dut.hw_cnt_q}, 32'd0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        branch_i     = 1'b0;
        #1;
        check_reset_outputs("midrst");
        stale_n = q_due.size();
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_pc    = 32'd0;
        exp_fetch = 32'd0;
        exp_redir = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        force_br  = 1'b1;
        force_tgt = tgt;
        step();
        force_br        = 1'b0;
        first_req_cyc   = -1;
        first_valid_cyc = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]    = 32'h0000_0013;
        mem[1]    = 32'h4505_0505;
        mem[2]    = 32'h0013_4501;
        mem[3]    = 32'h0000_0000;
        mem[8'h40] = 32'h0001_ABCD;

        #1 rst = 1'b1;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Boot and the directed instruction stream.
        gnt_pct = 100; ready_pct = 100; br_pct = 0; lat_min = 0; lat_max = 0;
        first_req_cyc = -1; first_valid_cyc = -1;
        repeat (14) step();
        check_eq("boot_first_req_cycle", first_req_cyc, 32'd1);
        check_eq("boot_first_valid_cycle", first_valid_cyc, 32'd3);
        check_eq("boot_hs_count_ge5", {31'd0, log_instr.size() >= 5}, 32'd1);
        if (log_instr.size() >= 5) begin
            check_eq("stream0_instr", log_instr[0], 32'h0000_0013);
            check_eq("stream0_pc",    log_pc[0],    32'h0000_0000);
            check_eq("stream0_cmp",   {31'd0, log_c[0]}, 32'd0);
            check_eq("stream1_instr", log_instr[1], 32'h0000_0505);
            check_eq("stream1_pc",    log_pc[1],    32'h0000_0004);
            check_eq("stream1_cmp",   {31'd0, log_c[1]}, 32'd1);
            check_eq("stream2_instr", log_instr[2], 32'h0000_4505);
            check_eq("stream2_pc",    log_pc[2],    32'h0000_0006);
            check_eq("stream3_instr", log_instr[3], 32'h0000_4501);
            check_eq("stream3_pc",    log_pc[3],    32'h0000_0008);
            check_eq("stream4_instr", log_instr[4], 32'h0000_0013);
            check_eq("stream4_pc",    log_pc[4],    32'h0000_000A);
            check_eq("stream4_cmp",   {31'd0, log_c[4]}, 32'd0);
        end

        // Misaligned redirect from an idle memory port (bit0 must be ignored).
        gnt_pct = 0;
        for (int k = 0; k < 20 && q_due.size() > 0; k++) step();
        check_eq("drain_before_redirect", q_due.size(), 32'd0);
        gnt_pct = 100;
        redirect_to(32'h0000_0103);
        r = cyc;
        repeat (6) step();
        check_eq("redir_req_latency",   first_req_cyc - r, 32'd1);
        check_eq("redir_instr_latency", first_valid_cyc - r, 32'd3);
        check_eq("redir_first_pc",      first_pc, 32'h0000_0102);
        check_eq("redir_first_instr",   first_instr, 32'h0000_0001);

        // Redirect while a response is outstanding: it must be discarded.
        lat_min = 2; lat_max = 2;
        first_req_cyc = -1;
        for (int k = 0; k < 10 && first_req_cyc < 0; k++) step();
        check_eq("kill_setup_grant", {31'd0, first_req_cyc >= 0}, 32'd1);
        lat_min = 0; lat_max = 0;
        redirect_to(32'h0000_0200);
        r = cyc;
        repeat (10) step();
        check_eq("kill_next_req_latency",   first_req_cyc - r, 32'd3);
        check_eq("kill_first_valid_latency", first_valid_cyc - r, 32'd5);
        check_eq("kill_first_pc",            first_pc, 32'h0000_0200);

        // Backpressure from a freshly flushed buffer.
        ready_pct = 0;
        redirect_to(32'h0000_0180);
        repeat (10) step();
        check_eq("bp_hw_cnt_full", {29'd0, dut.hw_cnt_q}, 32'd4);
        check_eq("bp_no_req",      {31'd0, mem_req_o}, 32'd0);
        check_eq("bp_valid_held",  {31'd0, instr_valid_o}, 32'd1);
        check_eq("bp_pc_held",     instr_pc_o, 32'h0000_0180);
        ready_pct = 100;
        repeat (20) step();

        // Random traffic with a reset in the middle.
        gnt_pct = 70; ready_pct = 75; br_pct = 3; lat_min = 0; lat_max = 3;
        repeat (1500) step();
        mid_reset();
        repeat (1500) step();
        check_eq("progress", {31'd0, n_hs > 500}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_aligner.md
# fetch_aligner

Instruction fetch aligner for the RV32IC core, sitting between the instruction memory port and the decode stage. It fetches aligned 32-bit words, buffers them as halfwords, and presents one instruction per handshake: a 16-bit compressed instruction, or a 32-bit instruction that may straddle a word boundary. The block also tracks the PC of each presented instruction and handles redirects from branches and jumps, including targets that are only halfword-aligned. Compressed instructions are passed through undecoded; expansion happens downstream.

## Interface
- BOOT_ADDR, 32'h0000_0000, fetch PC after reset (halfword-aligned)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- mem_req_o  out  1  fetch request, held until granted
- mem_addr_o  out  32  word address of request, bits[1:0]=0
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; exactly one per grant, ≥1 cycle after the grant
- mem_rdata_i  in  32  read word, little-endian halfwords
- instr_valid_o  out  1  instr_o holds a complete instruction
- instr_ready_i  in  1  decode accepts the instruction
- instr_o  out  32  instruction; compressed instructions are zero-extended in [15:0]
- instr_pc_o  out  32  PC of instr_o
- instr_compressed_o  out  1  instr_o is 16-bit
- branch_i  in  1  redirect strobe
- branch_target_i  in  32  redirect target; bit0 ignored and forced to 0

## Operation
- Buffer: 4 halfword entries in FIFO order, with count hw_cnt in 0..4. Registers: head pc, fetch word address fetch_addr, outstanding flag, kill flag, drop_low flag.
- Head classification: head[1:0]!=2'b11 means compressed and needs 1 halfword; otherwise the instruction needs 2 halfwords.
- instr_valid_o = hw_cnt ≥ required halfwords. This is combinational from registers.
- Handshake is instr_valid_o && instr_ready_i. On handshake, pop 1 or 2 halfwords and advance pc by 2 or 4.
- Request: mem_req_o is asserted when there is no outstanding request, hw_cnt ≤ 2 after this cycle's pop, and branch_i=0. On grant: set outstanding and increment fetch_addr by 4.
- Response (mem_rvalid_i):
  - Clears outstanding.
  - If kill is set: discard the data and clear kill.
  - Else if drop_low is set: append only the upper halfword and clear drop_low.
  - Else: append both halfwords, lower first.
  - The append happens after the same-cycle pop.
- Redirect (branch_i), which has priority over all else:
  - Flush the buffer (hw_cnt=0).
  - pc = target & ~1.
  - fetch_addr = target & ~3.
  - drop_low = target[1].
  - kill = outstanding && !mem_rvalid_i this cycle.
  - A same-cycle handshake is ignored, because the buffer is flushed.
  - No request is issued in the redirect cycle.
- Overflow is impossible by construction. The bench asserts hw_cnt ≤ 4 at all times.

## Timing
- Reset values:
  - mem_req_o=0, mem_addr_o=BOOT_ADDR&~3.
  - instr_valid_o=0, instr_o=0, instr_pc_o=BOOT_ADDR, instr_compressed_o=0.
  - hw_cnt=0; outstanding, kill and drop_low are 0 (drop_low=BOOT_ADDR[1]).
- mem_req_o rises in the first cycle after rst deasserts.
- Latency:
  - With grant in cycle N and rvalid in N+1, instr_valid_o is high in N+2.
  - After a redirect in cycle R, the earliest request is R+1 and the earliest instruction is R+3.
- Steady state: one word request outstanding at most. Sustains 1 instruction/cycle for compressed code when rvalid follows grant by 1 cycle.
- instr_ready_i low: all instr_* outputs are held stable and no pop occurs. Fetch continues until the buffer holds 4 halfwords.
- rst asserted mid-transaction: all state returns to reset values immediately. Any later mem_rvalid_i from the old request is ignored, because outstanding=0.

## Test plan
- Reset/boot: BOOT_ADDR=0, memory replies with 1-cycle latency, word0=32'h0000_0013 -> mem_addr_o=0 first; instr_o=32'h0000_0013, pc=0, compressed=0.
- Mixed stream: word1=32'h4505_0505 -> instr 32'h0000_0505 at pc 4 (compressed), then 32'h0000_4505 at pc 6 (compressed).
- Straddle: word2=32'h0013_4501, word3=32'h0000_0000 -> 32'h0000_4501 at pc 8 (compressed), then 32'h0000_0013 at pc 0xA (32-bit, uses both words).
- Misaligned redirect: branch_i with target 0x102 -> mem_addr_o=0x100; lower half of that word dropped; first instr_pc_o=0x102.
- Redirect with request outstanding: branch_i while awaiting a response -> that response is discarded, the next request goes to the target, and no stale instruction reaches instr_valid_o.
- Backpressure: instr_ready_i low for 10 cycles -> outputs stable, hw_cnt saturates at 4, mem_req_o low. On release, instructions drain in order with no loss or duplication.
